// File: rtl/adc_ltc2308_ctrl.sv
// LTC2308 frame controller: CONVST pulse, 12-clock SPI exchange of config and result.
// Latency: data_valid at T0+1+CONV_CYCLES+24*SCLK_HALF after start is accepted in IDLE.
// Backpressure: none; start is only looked at in IDLE, and requests while busy are dropped.
// Ports: CLOCK_50/reset (async, active-high); start/ch request a frame; busy, data_valid,
//        data, data_ch report results; ADC_CONVST/ADC_SCLK/ADC_DIN/ADC_DOUT go to the LTC2308.
module adc_ltc2308_ctrl #(
    parameter int CONV_CYCLES = 80,
    parameter int SCLK_HALF   = 2
) (
    input  logic        CLOCK_50,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  ch,
    output logic        busy,
    output logic        data_valid,
    output logic [11:0] data,
    output logic [2:0]  data_ch,
    output logic        ADC_CONVST,
    output logic        ADC_SCLK,
    output logic        ADC_DIN,
    input  logic        ADC_DOUT
);

    localparam int CNT_MAX = (CONV_CYCLES > SCLK_HALF) ? CONV_CYCLES : SCLK_HALF;
    localparam int CW      = $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {IDLE, CONV, SHIFT, DONE} state_t;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic [3:0]    bit_idx;
    logic [5:0]    cfg;
    logic [11:0]   shreg;
    logic [2:0]    cur_ch;
    logic [2:0]    prev_ch;
    logic          sclk;
    logic          conv_last;
    logic          half_last;
    logic          shift_last;

    assign conv_last  = (cnt == CW'(CONV_CYCLES - 1));
    assign half_last  = (cnt == CW'(SCLK_HALF - 1));
    // Last cycle of the high half of SCLK period 11 closes the frame.
    assign shift_last = half_last && sclk && (bit_idx == 4'd11);

    // SCLK comes straight from a flop so the pin never glitches.
    assign ADC_SCLK = sclk;

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        busy       = 1'b0;
        data_valid = 1'b0;
        ADC_CONVST = 1'b0;
        ADC_DIN    = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = CONV;
            end
            CONV: begin
                busy       = 1'b1;
                ADC_CONVST = 1'b1;
                if (conv_last) state_nxt = SHIFT;
            end
            SHIFT: begin
                busy = 1'b1;
                // Config word goes out MSB first over periods 0..5, zeros afterwards.
                if (bit_idx < 4'd6) ADC_DIN = cfg[3'd5 - bit_idx[2:0]];
                if (shift_last) state_nxt = DONE;
            end
            DONE: begin
                busy       = 1'b1;
                data_valid = 1'b1;
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            cnt     <= '0;
            bit_idx <= '0;
            cfg     <= '0;
            shreg   <= '0;
            cur_ch  <= '0;
            prev_ch <= '0;
            sclk    <= 1'b0;
            data    <= '0;
            data_ch <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        cur_ch <= ch;
                        // S/D=1, O/S=ch[0], S1=ch[2], S0=ch[1], UNI=1, SLP=0
                        cfg    <= {1'b1, ch[0], ch[2], ch[1], 1'b1, 1'b0};
                        cnt    <= '0;
                    end
                end
                CONV: begin
                    if (conv_last) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        sclk    <= 1'b0;
                        shreg   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                SHIFT: begin
                    if (half_last) begin
                        cnt <= '0;
                        if (!sclk) begin
                            // Rising SCLK edge: capture DOUT on this same clock edge.
                            sclk  <= 1'b1;
                            shreg <= {shreg[10:0], ADC_DOUT};
                        end else begin
                            sclk    <= 1'b0;
                            bit_idx <= bit_idx + 4'd1;
                            if (bit_idx == 4'd11) begin
                                // The LTC2308 converts with the previous frame's config,
                                // so this result belongs to prev_ch.
                                data    <= shreg;
                                data_ch <= prev_ch;
                            end
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    prev_ch <= cur_ch;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_adc_ltc2308_ctrl.sv
module tb_adc_ltc2308_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #10 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          cyc;
        logic [11:0] d;
        logic [2:0]  c;
        logic [5:0]  din;
        int          rises;
        int          conv;
        bit          late;
    } ev_t;

    // Instance A: default parameters
    logic        start_a = 1'b0;
    logic [2:0]  ch_a = 3'd0;
    logic        busy_a, dv_a, convst_a, sclk_a, din_a;
    logic        dout_a = 1'b0;
    logic [11:0] data_a;
    logic [2:0]  dch_a;

    // Instance B: SCLK_HALF=1, CONV_CYCLES=4
    logic        start_b = 1'b0;
    logic [2:0]  ch_b = 3'd0;
    logic        busy_b, dv_b, convst_b, sclk_b, din_b;
    logic        dout_b = 1'b0;
    logic [11:0] data_b;
    logic [2:0]  dch_b;

    adc_ltc2308_ctrl dut_a (
        .CLOCK_50(clk), .reset(rst), .start(start_a), .ch(ch_a),
        .busy(busy_a), .data_valid(dv_a), .data(data_a), .data_ch(dch_a),
        .ADC_CONVST(convst_a), .ADC_SCLK(sclk_a), .ADC_DIN(din_a), .ADC_DOUT(dout_a)
    );

    adc_ltc2308_ctrl #(.CONV_CYCLES(4), .SCLK_HALF(1)) dut_b (
        .CLOCK_50(clk), .reset(rst), .start(start_b), .ch(ch_b),
        .busy(busy_b), .data_valid(dv_b), .data(data_b), .data_ch(dch_b),
        .ADC_CONVST(convst_b), .ADC_SCLK(sclk_b), .ADC_DIN(din_b), .ADC_DOUT(dout_b)
    );

    // ADC model + frame observer for A
    int          conv_run_a = 0, last_conv_a = 0, rises_a = 0;
    logic [5:0]  dinw_a = '0;
    bit          late_a = 1'b0, stray_a = 1'b0;
    logic        sclk_q_a = 1'b0;
    logic [11:0] word_a = '0;
    logic [11:0] word_q_a[$];
    ev_t         ev_a[$];
    ev_t         e_a;

    always @(negedge clk) begin
        if (convst_a) begin
            if (conv_run_a == 0) begin
                if (word_q_a.size() > 0) word_a = word_q_a.pop_front();
                else word_a = '0;
                rises_a = 0; dinw_a = '0; late_a = 1'b0;
            end
            conv_run_a++;
        end else if (conv_run_a != 0) begin
            last_conv_a = conv_run_a;
            conv_run_a = 0;
        end
        if (sclk_a && !sclk_q_a) begin
            rises_a++;
            if (rises_a <= 6) dinw_a = {dinw_a[4:0], din_a};
        end
        if ((rises_a > 6 || (rises_a == 6 && !sclk_a)) && din_a) late_a = 1'b1;
        if ((!busy_a || convst_a) && (din_a || sclk_a)) stray_a = 1'b1;
        sclk_q_a = sclk_a;
        dout_a = (rises_a < 12) ? word_a[11 - rises_a] : 1'b0;
        if (dv_a) begin
            e_a = '{cyc, data_a, dch_a, dinw_a, rises_a, last_conv_a, late_a};
            ev_a.push_back(e_a);
        end
    end

    // ADC model + observer for B, also checks SCLK period length
    int          conv_run_b = 0, rises_b = 0, last_rise_b = 0;
    bit          gap_bad_b = 1'b0;
    logic        sclk_q_b = 1'b0;
    logic [11:0] word_b = '0;
    logic [11:0] word_q_b[$];
    ev_t         ev_b[$];
    ev_t         e_b;

    always @(negedge clk) begin
        if (convst_b) begin
            if (conv_run_b == 0) begin
                if (word_q_b.size() > 0) word_b = word_q_b.pop_front();
                else word_b = '0;
                rises_b = 0;
            end
            conv_run_b++;
        end else begin
            conv_run_b = 0;
        end
        if (sclk_b && !sclk_q_b) begin
            rises_b++;
            if (rises_b > 1 && (cyc - last_rise_b) != 2) gap_bad_b = 1'b1;
            last_rise_b = cyc;
        end
        sclk_q_b = sclk_b;
        dout_b = (rises_b < 12) ? word_b[11 - rises_b] : 1'b0;
        if (dv_b) begin
            e_b = '{cyc, data_b, dch_b, 6'd0, rises_b, 0, 1'b0};
            ev_b.push_back(e_b);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Config word from channel meaning: single-ended, odd flag, select bits, unipolar, awake.
    function automatic logic [5:0] din_of(input int c);
        return {1'b1, 1'(c % 2), 1'(c >= 4), 1'((c / 2) % 2), 1'b1, 1'b0};
    endfunction

    task automatic outs_zero_a(input string tag);
        chk({tag, "_busy"}, busy_a, 0);
        chk({tag, "_dv"}, dv_a, 0);
        chk({tag, "_data"}, data_a, 0);
        chk({tag, "_dch"}, dch_a, 0);
        chk({tag, "_convst"}, convst_a, 0);
        chk({tag, "_sclk"}, sclk_a, 0);
        chk({tag, "_din"}, din_a, 0);
    endtask

    task automatic wait_idle_a();
        int n = 0;
        while (busy_a && n < 500) begin step(); n++; end
        if (n >= 500) chk("idle_timeout_a", busy_a, 0);
    endtask

    task automatic start_frame_a(input logic [2:0] c, output int t0);
        wait_idle_a();
        start_a = 1'b1; ch_a = c; t0 = cyc;
        step();
        start_a = 1'b0; ch_a = 3'($urandom);
    endtask

    task automatic get_ev_a(output ev_t e, output bit got);
        for (int n = 0; n < 300 && ev_a.size() == 0; n++) step();
        got = (ev_a.size() > 0);
        if (got) e = ev_a.pop_front();
        else chk("dv_timeout_a", 0, 1);
    endtask

    task automatic check_ev_a(input ev_t e, input int t, input logic [11:0] w,
                              input logic [2:0] c, input logic [5:0] din);
        chk("dv_cycle", e.cyc, t);
        chk("data", e.d, w);
        chk("data_ch", e.c, c);
        chk("din_word", e.din, din);
        chk("sclk_pulses", e.rises, 12);
        chk("convst_len", e.conv, 80);
        chk("din_late_zero", e.late, 0);
    endtask

    logic [2:0] exp_prev;

    task automatic frame_a(input logic [2:0] c, input logic [11:0] w, input logic [5:0] din);
        int t0; ev_t e; bit got;
        word_q_a.push_back(w);
        start_frame_a(c, t0);
        chk("busy_t0p1", busy_a, 1);
        chk("convst_t0p1", convst_a, 1);
        get_ev_a(e, got);
        if (got) check_ev_a(e, t0 + 129, w, exp_prev, din);
        exp_prev = c;
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout cycle=%0d required=finish", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int t0, n;
        ev_t e;
        bit got;
        logic [11:0] w, w3[3];
        logic [2:0] c;

        // reset state
        repeat (3) step();
        outs_zero_a("reset");
        rst = 1'b0;
        step();
        exp_prev = 3'd0;

        // first frame and back-to-back directed channels
        frame_a(3'd5, 12'hA5C, 6'b111010);
        frame_a(3'd2, 12'($urandom), 6'b100110);
        frame_a(3'd7, 12'($urandom), 6'b111110);
        for (int i = 0; i < 4; i++) begin
            c = 3'($urandom_range(0, 7));
            frame_a(c, 12'($urandom), din_of(c));
        end

        // start pulses while busy (including DONE) are ignored
        w = 12'($urandom); c = 3'($urandom);
        word_q_a.push_back(w);
        start_frame_a(c, t0);
        while (cyc < t0 + 10) step();
        start_a = 1'b1; ch_a = ~c;
        step();
        start_a = 1'b0;
        while (cyc < t0 + 128) step();
        start_a = 1'b1;
        step(); step();
        start_a = 1'b0;
        chk("busy_t0p130", busy_a, 0);
        repeat (10) step();
        chk("busy_t0p140", busy_a, 0);
        chk("one_dv_only", ev_a.size(), 1);
        get_ev_a(e, got);
        if (got) check_ev_a(e, t0 + 129, w, exp_prev, din_of(c));
        exp_prev = c;

        // reset in the middle of SHIFT
        word_q_a.push_back(12'($urandom));
        start_frame_a(3'($urandom), t0);
        while (cyc < t0 + 100) step();
        rst = 1'b1;
        #1;
        outs_zero_a("midrst");
        step(); step();
        rst = 1'b0;
        exp_prev = 3'd0;
        repeat (40) step();
        chk("no_dv_after_abort", ev_a.size(), 0);
        frame_a(3'd3, 12'($urandom), din_of(3));

        // start held high: frames every 130 cycles, data_ch pipelined
        for (int i = 0; i < 3; i++) begin
            w3[i] = 12'($urandom);
            word_q_a.push_back(w3[i]);
        end
        wait_idle_a();
        start_a = 1'b1; ch_a = 3'd6; t0 = cyc;
        repeat (300) step();
        start_a = 1'b0;
        for (int i = 0; i < 3; i++) begin
            get_ev_a(e, got);
            if (got) begin
                check_ev_a(e, t0 + 129 + 130 * i, w3[i], exp_prev, din_of(6));
                exp_prev = 3'd6;
            end
        end

        // short-parameter instance: timing and extreme data words
        for (int i = 0; i < 2; i++) begin
            w = (i == 0) ? 12'hFFF : 12'h001;
            c = (i == 0) ? 3'd1 : 3'd4;
            word_q_b.push_back(w);
            n = 0;
            while (busy_b && n < 100) begin step(); n++; end
            start_b = 1'b1; ch_b = c; t0 = cyc;
            step();
            start_b = 1'b0;
            for (n = 0; n < 100 && ev_b.size() == 0; n++) step();
            if (ev_b.size() == 0) begin
                chk("dv_timeout_b", 0, 1);
            end else begin
                e = ev_b.pop_front();
                chk("b_dv_cycle", e.cyc, t0 + 29);
                chk("b_data", e.d, w);
                chk("b_data_ch", e.c, (i == 0) ? 0 : 1);
                chk("b_sclk_pulses", e.rises, 12);
            end
        end
        chk("b_sclk_period2", gap_bad_b, 0);
        chk("a_sclk_din_idle_low", stray_a, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/adc_ltc2308_ctrl.md
ADC_LTC2308_CTRL -- requirements
Module: adc_ltc2308_ctrl

Interface
REQ-001 Parameter CONV_CYCLES, default 80: clocks ADC_CONVST is held high, i.e. the conversion wait (1.6 us at 50 MHz).
REQ-002 Parameter SCLK_HALF, default 2: clocks per ADC_SCLK half-period (12.5 MHz SCLK at 50 MHz).
REQ-003 Clocking: one clock; reset is asynchronous and active-high.
REQ-004 CLOCK_50  in  1  system clock; all logic on its rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 start  in  1  request one conversion frame; sampled only in IDLE.
REQ-007 ch  in  3  single-ended channel (0-7) for the conversion started by this frame.
REQ-008 busy  out  1  high from the cycle after start is accepted through DONE.
REQ-009 data_valid  out  1  one-cycle pulse; data and data_ch are updated in the same cycle.
REQ-010 data  out  12  unsigned result shifted out in the frame.
REQ-011 data_ch  out  3  channel that data belongs to.
REQ-012 ADC_CONVST  out  1  LTC2308 conversion start.
REQ-013 ADC_SCLK  out  1  LTC2308 serial clock; idles low.
REQ-014 ADC_DIN  out  1  LTC2308 config input.
REQ-015 ADC_DOUT  in  1  LTC2308 serial data.

Function
REQ-016 The FSM SHALL have four states: IDLE, CONV, SHIFT and DONE.
REQ-017 IDLE: the FSM SHALL move to CONV when start=1 at cycle T0.
- In the same cycle, ch SHALL be latched into cur_ch.
- The 6-bit config word SHALL be latched as {1, ch[0], ch[2], ch[1], 1, 0}, i.e. S/D, O/S, S1, S0, UNI, SLP.
REQ-018 CONV: ADC_CONVST SHALL be 1 for exactly CONV_CYCLES cycles, T0+1 through T0+CONV_CYCLES, after which the FSM SHALL enter SHIFT.
REQ-019 SHIFT: ADC_CONVST=0; the block SHALL generate exactly 12 SCLK periods.
- Each period is SCLK_HALF cycles low followed by SCLK_HALF cycles high.
- SHIFT lasts 24*SCLK_HALF cycles.
REQ-020 ADC_DIN SHALL present config bit 5-k throughout SCLK period k (k=0..5), MSB first, and SHALL be 0 for periods 6..11.
REQ-021 ADC_DOUT SHALL be sampled on the clock edge where ADC_SCLK goes 0->1.
- Samples are shifted MSB first into a 12-bit register.
- The sample in period 0 is bit 11.
REQ-022 DONE: the block SHALL spend one cycle in DONE and then return to IDLE.
- In DONE: data_valid=1, data=shift register, data_ch=prev_ch, and then prev_ch<=cur_ch.
- data_valid occurs at cycle T0+1+CONV_CYCLES+24*SCLK_HALF; this is T0+129 with the defaults.
REQ-023 Pipelining: the LTC2308 applies the config sent in frame N to conversion N+1. data_ch SHALL therefore report the channel from the previous frame.
REQ-024 busy SHALL be 1 in CONV, SHIFT and DONE, and 0 in IDLE.
REQ-025 start SHALL be ignored while busy=1, including during DONE. A start held high continuously SHALL begin a new frame in the first IDLE cycle after DONE.
REQ-026 data and data_ch SHALL hold their values between data_valid pulses.
REQ-027 ADC_SCLK SHALL be 0 outside SHIFT, and ADC_DIN SHALL be 0 outside SHIFT.

Reset
REQ-028 On reset=1 the block SHALL act immediately, without waiting for a clock edge.
- The FSM goes to IDLE.
- ADC_CONVST, ADC_SCLK, ADC_DIN, busy and data_valid go to 0.
- data goes to 12'h000; data_ch, prev_ch and cur_ch go to 3'd0; the config, shift and counter registers are cleared.
REQ-029 If reset asserts mid-frame, the partial frame SHALL be discarded with no data_valid pulse. After release, the first start SHALL begin a complete frame.
REQ-030 For the first frame after reset, data_ch SHALL report 3'd0, which is the LTC2308 power-up channel.

Verification
REQ-031 Scenario: reset released, start=1 for one cycle with ch=5, ADC model driving 12'hA5C.
- ADC_CONVST is high for exactly 80 cycles, then 12 SCLK pulses occur.
- ADC_DIN carries 111010.
- data_valid pulses at T0+129 with data=12'hA5C and data_ch=0.
REQ-032 Scenario: back-to-back frames with ch=5, then ch=2, then ch=7.
- DIN words are 111010, 100110, 111110.
- data_ch sequence is 0, 5, 2.
REQ-033 Scenario: start pulsed at T0+10 and at T0+128, i.e. while busy.
- Both pulses are ignored; exactly one data_valid occurs.
- busy=0 at T0+130.
REQ-034 Scenario: reset asserted at T0+100, during SHIFT.
- All outputs are 0 in the same cycle; no data_valid occurs.
- A subsequent start with ch=3 completes normally with data_ch=0.
REQ-035 Scenario: start held high for 300 cycles.
- Consecutive frames begin one cycle after each DONE, giving a data_valid spacing of 130 cycles.
REQ-036 Scenario: SCLK_HALF=1 and CONV_CYCLES=4.
- data_valid occurs at T0+29.
- The SCLK period is 2 cycles and the DOUT samples are correct for 12'hFFF and 12'h001.
